// File: rtl/rv32_decode_stage.sv
// RV32 decode-stage pipeline register: classifies the fetched instruction,
// holds it under valid/ready, inserts load-use bubbles and counts stall cycles.
package rv32_decode_pkg;
  typedef enum logic [2:0] {
    INSTR_R_TYPE = 3'd0,
    INSTR_I_TYPE = 3'd1,
    INSTR_S_TYPE = 3'd2,
    INSTR_B_TYPE = 3'd3,
    INSTR_U_TYPE = 3'd4,
    INSTR_J_TYPE = 3'd5
  } instr_type_t;

  typedef struct packed {
    instr_type_t instr_type;
    logic        illegal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } dec_fields_t;
endpackage

module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid,
  output logic                 fetch_ready,
  input  logic [31:0]          fetch_instr,
  input  logic [31:0]          fetch_pc,
  input  logic                 flush,
  input  logic                 ex_load_valid,
  input  logic [4:0]           ex_load_rd,
  output logic                 dec_valid,
  input  logic                 exec_ready,
  output logic [31:0]          dec_instr,
  output logic [31:0]          dec_pc,
  output instr_type_t          dec_instr_type,
  output logic [4:0]           dec_rs1,
  output logic [4:0]           dec_rs2,
  output logic [4:0]           dec_rd,
  output logic                 dec_illegal,
  output logic [CNT_WIDTH-1:0] hazard_stall_cnt
);

  logic                 occ;
  logic [31:0]          instr_q;
  logic [31:0]          pc_q;
  dec_fields_t          fields_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic        hazard_c;
  logic        fire_in_c;
  logic        fire_out_c;
  logic [31:0] cap_instr_c;
  dec_fields_t fields_c;

  // Reset and flush load the NOP through the same decoder as a fetched word
  assign cap_instr_c = (rst || flush) ? NOP_INSTR : fetch_instr;

  always_comb begin
    fields_c            = '0;
    fields_c.instr_type = INSTR_R_TYPE;
    fields_c.rs1        = cap_instr_c[19:15];
    fields_c.rs2        = cap_instr_c[24:20];
    fields_c.rd         = cap_instr_c[11:7];
    // Illegal encodings (incl. compressed, instr[1:0] != 2'b11) stay R-type so the immediate is 0
    case (cap_instr_c[6:0])
      7'b0110011: begin
        fields_c.instr_type = INSTR_R_TYPE;
        fields_c.uses_rs1   = 1'b1;
        fields_c.uses_rs2   = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fields_c.instr_type = INSTR_I_TYPE;
        fields_c.uses_rs1   = 1'b1;
      end
      7'b0100011: begin
        fields_c.instr_type = INSTR_S_TYPE;
        fields_c.uses_rs1   = 1'b1;
        fields_c.uses_rs2   = 1'b1;
      end
      7'b1100011: begin
        fields_c.instr_type = INSTR_B_TYPE;
        fields_c.uses_rs1   = 1'b1;
        fields_c.uses_rs2   = 1'b1;
      end
      7'b0110111, 7'b0010111: fields_c.instr_type = INSTR_U_TYPE;
      7'b1101111:             fields_c.instr_type = INSTR_J_TYPE;
      default:                fields_c.illegal    = 1'b1;
    endcase
  end

  assign hazard_c = occ && ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((fields_q.uses_rs1 && (fields_q.rs1 == ex_load_rd)) ||
                     (fields_q.uses_rs2 && (fields_q.rs2 == ex_load_rd)));

  assign dec_valid   = occ && !hazard_c;
  assign fire_out_c  = dec_valid && exec_ready;
  assign fetch_ready = !occ || fire_out_c;
  assign fire_in_c   = fetch_valid && fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 1'b0;
      instr_q  <= cap_instr_c;
      pc_q     <= '0;
      fields_q <= fields_c;
      cnt_q    <= '0;
    end else begin
      // A fetch accepted alongside a flush is consumed and discarded
      if (flush) begin
        occ      <= 1'b0;
        instr_q  <= cap_instr_c;
        fields_q <= fields_c;
      end else if (fire_in_c) begin
        occ      <= 1'b1;
        instr_q  <= cap_instr_c;
        pc_q     <= fetch_pc;
        fields_q <= fields_c;
      end else if (fire_out_c) begin
        occ <= 1'b0;
      end
      if (hazard_c && !flush && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign dec_instr        = instr_q;
  assign dec_pc           = pc_q;
  assign dec_instr_type   = fields_q.instr_type;
  assign dec_rs1          = fields_q.rs1;
  assign dec_rs2          = fields_q.rs2;
  assign dec_rd           = fields_q.rd;
  assign dec_illegal      = fields_q.illegal;
  assign hazard_stall_cnt = cnt_q;

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Decode-stage pipeline register between fetch and the exec stage.
- Classifies each fetched instruction into instr_type_t, extracts register indices and flags illegal encodings; the exec stage consumes these together with the raw instruction to build its immediate.
- Holds one instruction under a valid/ready handshake.
- Inserts load-use bubbles and counts hazard stall cycles.

Parameters:
NOP_INSTR, 32'h0000_0013, value driven on dec_instr at reset and after flush (addi x0,x0,0)
CNT_WIDTH, 32, width of the saturating hazard-stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_valid  in  1  fetch presents an instruction
fetch_ready  out  1  decode accepts this cycle
fetch_instr  in  32  instruction word (rv32_word)
fetch_pc  in  32  instruction PC (rv32_word)
flush  in  1  squash held instruction (branch/jump redirect from exec)
ex_load_valid  in  1  exec stage currently holds a load
ex_load_rd  in  5  destination of that load
dec_valid  out  1  decoded instruction offered to exec
exec_ready  in  1  exec accepts this cycle
dec_instr  out  32  held instruction word
dec_pc  out  32  held PC
dec_instr_type  out  instr_type_t  classification for the immediate generator
dec_rs1  out  5  instr[19:15]
dec_rs2  out  5  instr[24:20]
dec_rd  out  5  instr[11:7]
dec_illegal  out  1  unsupported encoding
hazard_stall_cnt  out  CNT_WIDTH  saturating count of load-use stall cycles

Behaviour:
- Internal state: occ (entry full), held instr/pc, decoded fields registered at capture, stall counter.
- Decode at capture, by opcode instr[6:0]:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Any other opcode, or instr[1:0] != 2'b11 -> dec_illegal=1 and dec_instr_type=INSTR_R_TYPE, so the downstream immediate resolves to 0.
- Register usage: R/S/B use rs1 and rs2; I uses rs1 only; U/J use neither.
- hazard (combinational) = occ & ex_load_valid & (ex_load_rd != 0) & ((uses_rs1 & dec_rs1==ex_load_rd) | (uses_rs2 & dec_rs2==ex_load_rd)).
- Handshake:
  - dec_valid = occ & ~hazard.
  - fire_out = dec_valid & exec_ready.
  - fetch_ready = ~occ | fire_out.
  - fire_in = fetch_valid & fetch_ready.
- Next state, in priority order:
  - rst: occ=0, dec_instr=NOP_INSTR, dec_pc=0, decoded fields = decode(NOP_INSTR) (I type, rd/rs=0, illegal=0), counter=0.
  - flush: occ=0, dec_instr=NOP_INSTR, fields as for NOP; dec_pc unchanged. A fire_in in the same cycle is dropped: fetch handshake completes but the instruction is discarded.
  - fire_in: capture instr/pc/decoded fields, occ=1. This covers simultaneous fire_out (back-to-back throughput of 1/cycle).
  - fire_out without fire_in: occ=0; data outputs hold their last value.
  - otherwise: hold.
- Latency: fetch handshake in cycle N -> dec_valid in cycle N+1, unless hazard.
- Outputs remain stable while dec_valid & ~exec_ready (no change until consumed or flushed).
- Counter: +1 on each cycle with occ & hazard & ~flush; saturates at all-ones; cleared only by rst.
- fetch_ready is purely combinational from state, exec_ready and the ex_load_* inputs; it never depends on fetch_valid.

Test Plan:
- Reset: assert rst 2 cycles with fetch_valid=1 -> dec_valid=0, dec_instr=0x00000013, hazard_stall_cnt=0, fetch_ready=1 after release.
- Stream: 0x00500093 (addi), 0x002081B3 (add), 0x00112223 (sw), 0xFE209EE3 (bne), 0x123450B7 (lui), 0x0080006F (jal), exec_ready=1 -> one per cycle, types I,R,S,B,U,J in order, rs1/rs2/rd match fields, illegal=0.
- Backpressure: exec_ready=0 for 3 cycles with instr 0x002081B3 held -> outputs stable, fetch_ready=0. Release -> consumed and next accepted in the same cycle.
- Load-use: held add x3,x1,x2 with ex_load_valid=1, ex_load_rd=2 for 2 cycles -> dec_valid=0, counter=2. Same with ex_load_rd=0, or held lui with rd match -> no stall, counter unchanged.
- Flush: flush=1 while occ=1 and fetch_valid=1 -> next cycle dec_valid=0, dec_instr=0x00000013, the fetched instruction is not delivered.
- Illegal: 0x0000000B and 0x00000001 -> dec_illegal=1, dec_instr_type=INSTR_R_TYPE. Counter saturation check with CNT_WIDTH=4: 20 hazard cycles -> 0xF.
